// File: rtl/riscv_decode_stage.sv
// RISC-V decode stage: RV32I/C decode, register-limit check, small FIFO to execute.
// Latency: one cycle minimum from push to out_valid; no bypass path.
// Backpressure: in_ready = level < FIFO_DEPTH from registered state only; optional stats via RISCV_DECODE_STAGE_STATS_EN.

module riscv_i32c_decode (
   input  logic        i32c,
   input  logic        i32m,
   input  logic        i32m_fuse,
   input  logic        coproc_disable,
   input  logic [2:0]  mode,
   input  logic [31:0] data,
   output logic [4:0]  rs1,
   output logic        rs1_valid,
   output logic [4:0]  rs2,
   output logic        rs2_valid,
   output logic [4:0]  rd,
   output logic        rd_written,
   output logic        csr_access,
   output logic [31:0] immediate,
   output logic [4:0]  immediate_shift,
   output logic        immediate_valid,
   output logic [3:0]  op,
   output logic [3:0]  subop,
   output logic        requires_machine_mode,
   output logic        memory_read_unsigned,
   output logic [1:0]  memory_width,
   output logic        illegal,
   output logic        is_compressed,
   output logic [1:0]  ext
);
   localparam logic [3:0] OP_ALU = 4'd0, OP_LOAD = 4'd1, OP_STORE = 4'd2, OP_BRANCH = 4'd3,
                          OP_JAL = 4'd4, OP_JALR = 4'd5, OP_LUI = 4'd6, OP_AUIPC = 4'd7,
                          OP_MULDIV = 4'd8, OP_SYSTEM = 4'd9, OP_CSR = 4'd10, OP_FENCE = 4'd11,
                          OP_COPROC = 4'd12, OP_ILLEGAL = 4'd15;

   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        bad, priv_ok;

   assign f3      = data[14:12];
   assign f7      = data[31:25];
   assign imm_i   = {{20{data[31]}}, data[31:20]};
   assign imm_s   = {{20{data[31]}}, data[31:25], data[11:7]};
   assign imm_b   = {{19{data[31]}}, data[31], data[7], data[30:25], data[11:8], 1'b0};
   assign imm_u   = {data[31:12], 12'd0};
   assign imm_j   = {{11{data[31]}}, data[31], data[19:12], data[20], data[30:21], 1'b0};
   assign priv_ok = mode[2] | (mode[1:0] == 2'b11);

   always_comb begin
      rs1 = data[19:15];  rs1_valid = 1'b0;
      rs2 = data[24:20];  rs2_valid = 1'b0;
      rd  = data[11:7];   rd_written = 1'b0;
      csr_access = 1'b0;  immediate = '0;  immediate_shift = '0;  immediate_valid = 1'b0;
      op = OP_ILLEGAL;    subop = {1'b0, f3};
      requires_machine_mode = 1'b0;
      memory_read_unsigned = 1'b0;  memory_width = 2'd0;
      is_compressed = 1'b0;  ext = 2'd0;  bad = 1'b0;
      if (data[1:0] != 2'b11) begin
         // Only the compressed forms execute needs without expansion: ADDI, LI, MV, ADD.
         is_compressed = 1'b1;
         op = OP_ALU;  subop = 4'd0;
         rd = data[11:7];  rs1 = data[11:7];  rs2 = data[6:2];
         immediate = {{26{data[12]}}, data[12], data[6:2]};
         case ({data[1:0], data[15:13]})
            5'b01_000: begin rs1_valid = 1'b1; rd_written = 1'b1; immediate_valid = 1'b1; end
            5'b01_010: begin rs1 = 5'd0; rd_written = 1'b1; immediate_valid = 1'b1; end
            5'b10_100: begin
               immediate = '0;  rd_written = 1'b1;  rs2_valid = 1'b1;
               if (data[6:2] == 5'd0) bad = 1'b1;
               else if (data[12])     rs1_valid = 1'b1;
               else                   rs1 = 5'd0;
            end
            default: begin bad = 1'b1; op = OP_ILLEGAL; end
         endcase
         if (!i32c) bad = 1'b1;
      end else begin
         case (data[6:0])
            7'b0110111: begin op = OP_LUI;   rd_written = 1'b1; immediate = imm_u; immediate_valid = 1'b1; end
            7'b0010111: begin op = OP_AUIPC; rd_written = 1'b1; immediate = imm_u; immediate_valid = 1'b1; end
            7'b1101111: begin op = OP_JAL;   rd_written = 1'b1; immediate = imm_j; immediate_valid = 1'b1; end
            7'b1100111: begin
               op = OP_JALR; rs1_valid = 1'b1; rd_written = 1'b1; immediate = imm_i; immediate_valid = 1'b1;
               if (f3 != 3'b000) bad = 1'b1;
            end
            7'b1100011: begin
               op = OP_BRANCH; rs1_valid = 1'b1; rs2_valid = 1'b1; immediate = imm_b; immediate_valid = 1'b1;
               if (f3 == 3'b010 || f3 == 3'b011) bad = 1'b1;
            end
            7'b0000011: begin
               op = OP_LOAD; rs1_valid = 1'b1; rd_written = 1'b1; immediate = imm_i; immediate_valid = 1'b1;
               memory_width = f3[1:0];  memory_read_unsigned = f3[2];
               if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) bad = 1'b1;
            end
            7'b0100011: begin
               op = OP_STORE; rs1_valid = 1'b1; rs2_valid = 1'b1; immediate = imm_s; immediate_valid = 1'b1;
               memory_width = f3[1:0];
               if (f3[2] || f3 == 3'b011) bad = 1'b1;
            end
            7'b0010011: begin
               op = OP_ALU; rs1_valid = 1'b1; rd_written = 1'b1; immediate = imm_i; immediate_valid = 1'b1;
               if (f3 == 3'b001 || f3 == 3'b101) begin
                  immediate_shift = data[24:20];
                  subop = {data[30], f3};
                  if (f7 != 7'h00 && !(f3 == 3'b101 && f7 == 7'h20)) bad = 1'b1;
               end
            end
            7'b0110011: begin
               rs1_valid = 1'b1; rs2_valid = 1'b1; rd_written = 1'b1;
               if (f7 == 7'h01) begin
                  op = OP_MULDIV;  ext = {i32m_fuse, 1'b1};  bad = !i32m;
               end else begin
                  op = OP_ALU;  subop = {data[30], f3};
                  if (f7 != 7'h00 && !(f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) bad = 1'b1;
               end
            end
            7'b0001111: begin op = OP_FENCE; if (f3[2:1] != 2'b00) bad = 1'b1; end
            7'b1110011: begin
               if (f3 == 3'b000) begin
                  op = OP_SYSTEM;
                  case (data)
                     32'h00000073: subop = 4'd0;
                     32'h00100073: subop = 4'd1;
                     32'h30200073: begin subop = 4'd2; requires_machine_mode = 1'b1; end
                     32'h10500073: subop = 4'd3;
                     default:      bad = 1'b1;
                  endcase
               end else if (f3 == 3'b100) begin
                  bad = 1'b1;
               end else begin
                  // CSR address rides in the immediate; the zimm form reuses immediate_shift.
                  op = OP_CSR; csr_access = 1'b1; rd_written = 1'b1;
                  immediate = {20'd0, data[31:20]}; immediate_valid = 1'b1;
                  requires_machine_mode = (data[29:28] == 2'b11);
                  if (f3[2]) immediate_shift = data[19:15];
                  else       rs1_valid = 1'b1;
               end
            end
            7'b0001011: begin
               op = OP_COPROC; ext = 2'b10; rs1_valid = 1'b1; rs2_valid = 1'b1; rd_written = 1'b1;
               if (coproc_disable) bad = 1'b1;
            end
            default: bad = 1'b1;
         endcase
      end
      illegal = bad | (requires_machine_mode & ~priv_ok);
   end
endmodule

module riscv_decode_stage #(
   parameter int NUM_REGS   = 32,
   parameter int FIFO_DEPTH = 2,
   parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          riscv_config__i32c,
   input  logic          riscv_config__e32,
   input  logic          riscv_config__i32m,
   input  logic          riscv_config__i32m_fuse,
   input  logic          riscv_config__coproc_disable,
   input  logic          riscv_config__unaligned_mem,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    instruction__mode,
   input  logic [31:0]   instruction__data,
   input  logic [31:0]   in_pc,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_pc,
   output logic [4:0]    out_idecode__rs1,
   output logic          out_idecode__rs1_valid,
   output logic [4:0]    out_idecode__rs2,
   output logic          out_idecode__rs2_valid,
   output logic [4:0]    out_idecode__rd,
   output logic          out_idecode__rd_written,
   output logic          out_idecode__csr_access,
   output logic [31:0]   out_idecode__immediate,
   output logic [4:0]    out_idecode__immediate_shift,
   output logic          out_idecode__immediate_valid,
   output logic [3:0]    out_idecode__op,
   output logic [3:0]    out_idecode__subop,
   output logic          out_idecode__requires_machine_mode,
   output logic          out_idecode__memory_read_unsigned,
   output logic [1:0]    out_idecode__memory_width,
   output logic          out_idecode__illegal,
   output logic          out_idecode__is_compressed,
   output logic [1:0]    out_idecode__ext,
   output logic          out_reg_illegal,
   output logic [LW-1:0] fifo_level
`ifdef RISCV_DECODE_STAGE_STATS_EN
   ,
   input  logic          stats_clear,
   output logic [31:0]   stat_decoded,
   output logic [31:0]   stat_illegal
`endif
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int EW = 106;

   logic [4:0]  d_rs1, d_rs2, d_rd, d_shift;
   logic        d_rs1_valid, d_rs2_valid, d_rd_written, d_csr, d_imm_valid;
   logic [31:0] d_imm;
   logic [3:0]  d_op, d_subop;
   logic        d_rmm, d_unsigned, d_illegal, d_is_c;
   logic [1:0]  d_width, d_ext;
   logic [5:0]  lim;
   logic        reg_bad, wr_illegal, push, pop, unused_cfg;
   logic [EW-1:0] wr_entry;
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level;

   riscv_i32c_decode u_dec (
      .i32c(riscv_config__i32c), .i32m(riscv_config__i32m), .i32m_fuse(riscv_config__i32m_fuse),
      .coproc_disable(riscv_config__coproc_disable), .mode(instruction__mode), .data(instruction__data),
      .rs1(d_rs1), .rs1_valid(d_rs1_valid), .rs2(d_rs2), .rs2_valid(d_rs2_valid),
      .rd(d_rd), .rd_written(d_rd_written), .csr_access(d_csr), .immediate(d_imm),
      .immediate_shift(d_shift), .immediate_valid(d_imm_valid), .op(d_op), .subop(d_subop),
      .requires_machine_mode(d_rmm), .memory_read_unsigned(d_unsigned), .memory_width(d_width),
      .illegal(d_illegal), .is_compressed(d_is_c), .ext(d_ext)
   );

   // Alignment depends on the runtime address, so it is the memory stage's concern.
   assign unused_cfg = riscv_config__unaligned_mem;

   assign lim        = riscv_config__e32 ? 6'd16 : 6'(NUM_REGS);
   assign reg_bad    = (d_rs1_valid  && {1'b0, d_rs1} >= lim) ||
                       (d_rs2_valid  && {1'b0, d_rs2} >= lim) ||
                       (d_rd_written && {1'b0, d_rd}  >= lim);
   assign wr_illegal = d_illegal | reg_bad;
   assign wr_entry   = {in_pc, reg_bad, d_rs1, d_rs1_valid, d_rs2, d_rs2_valid, d_rd, d_rd_written,
                        d_csr, d_imm, d_shift, d_imm_valid, d_op, d_subop, d_rmm, d_unsigned,
                        d_width, wr_illegal, d_is_c, d_ext};

   assign in_ready   = (level < LW'(FIFO_DEPTH));
   assign out_valid  = (level != '0);
   assign fifo_level = level;
   assign push       = in_valid && in_ready;
   assign pop        = out_valid && out_ready;

   assign {out_pc, out_reg_illegal, out_idecode__rs1, out_idecode__rs1_valid, out_idecode__rs2,
           out_idecode__rs2_valid, out_idecode__rd, out_idecode__rd_written, out_idecode__csr_access,
           out_idecode__immediate, out_idecode__immediate_shift, out_idecode__immediate_valid,
           out_idecode__op, out_idecode__subop, out_idecode__requires_machine_mode,
           out_idecode__memory_read_unsigned, out_idecode__memory_width, out_idecode__illegal,
           out_idecode__is_compressed, out_idecode__ext} = mem[rd_ptr];

   // Storage is cleared on reset so every output reads zero straight out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_entry;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

`ifdef RISCV_DECODE_STAGE_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_decoded <= '0;
         stat_illegal <= '0;
      end else if (stats_clear) begin
         stat_decoded <= '0;
         stat_illegal <= '0;
      end else if (push && !flush) begin
         if (stat_decoded != '1) stat_decoded <= stat_decoded + 1'b1;
         if (wr_illegal && stat_illegal != '1) stat_illegal <= stat_illegal + 1'b1;
      end
   end
`endif
endmodule
